sram_width_packer: RTL and testbench



---
 rtl/sram_width_packer.sv | 129 ++++++++++++
 tb/tb_sram_width_packer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_width_packer.sv
// Width-conversion engine: packs RATIO narrow input-RAM words into each wide
// output-RAM word under a start/busy/done handshake.
module sram_width_packer #(
    parameter int IN_W     = 8,
    parameter int RATIO    = 2,
    parameter int IN_DEPTH = 32,
    localparam int OUT_W     = IN_W * RATIO,
    localparam int OUT_DEPTH = IN_DEPTH / RATIO,
    localparam int IN_AW     = $clog2(IN_DEPTH),
    localparam int OUT_AW    = $clog2(OUT_DEPTH),
    localparam int LEN_W     = OUT_AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_in_we,
    input  logic [IN_AW-1:0]  ram_in_addr_wr,
    input  logic [IN_W-1:0]   ram_in_data_wr,
    input  logic [OUT_AW-1:0] ram_out_addr_rd,
    output logic [OUT_W-1:0]  ram_out_data_rd,
    input  logic              start_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic              order_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [LEN_W-1:0]  words_done_out
);

    localparam int LANE_W = $clog2(RATIO);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(OUT_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        GATHER,
        WRITE
    } state_t;

    state_t              state;
    logic [IN_AW-1:0]    rd_ptr;
    logic [OUT_AW-1:0]   wr_ptr;
    logic [LANE_W-1:0]   lane;
    logic [LANE_W-1:0]   lane_sel;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    len_clamped;
    logic                order_q;
    logic [OUT_W-1:0]    pack_q;
    logic [IN_W-1:0]     ram_in_rd;

    logic [IN_W-1:0]     ram_in  [IN_DEPTH];
    logic [OUT_W-1:0]    ram_out [OUT_DEPTH];

    // RAM arrays: synchronous write, asynchronous read, contents never reset
    always_ff @(posedge clk) begin
        if (ram_in_we)
            ram_in[ram_in_addr_wr] <= ram_in_data_wr;
    end

    always_ff @(posedge clk) begin
        if (state == WRITE)
            ram_out[wr_ptr] <= pack_q;
    end

    assign ram_in_rd       = ram_in[rd_ptr];
    assign ram_out_data_rd = ram_out[ram_out_addr_rd];

    always_comb begin
        len_clamped = (len_in > MAX_LEN) ? MAX_LEN : len_in;
        lane_sel    = order_q ? (LAST_LANE - lane) : lane;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            words_done_out <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            lane           <= '0;
            len_q          <= '0;
            order_q        <= 1'b0;
            pack_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        len_q          <= len_clamped;
                        order_q        <= order_in;
                        rd_ptr         <= '0;
                        wr_ptr         <= '0;
                        lane           <= '0;
                        words_done_out <= '0;
                        if (len_clamped == '0) begin
                            done_out <= 1'b1;
                        end else begin
                            done_out <= 1'b0;
                            busy_out <= 1'b1;
                            state    <= GATHER;
                        end
                    end
                end
                GATHER: begin
                    pack_q[lane_sel*IN_W +: IN_W] <= ram_in_rd;
                    rd_ptr <= rd_ptr + IN_AW'(1);
                    lane   <= lane + LANE_W'(1);
                    if (lane == LAST_LANE)
                        state <= WRITE;
                end
                WRITE: begin
                    wr_ptr         <= wr_ptr + OUT_AW'(1);
                    words_done_out <= words_done_out + LEN_W'(1);
                    lane           <= '0;
                    if (words_done_out + LEN_W'(1) == len_q) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                    end else begin
                        state <= GATHER;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_width_packer.sv
// Directed bench for sram_width_packer: a RATIO=2 and a RATIO=4 instance share
// clock, reset and input-RAM load port.
module tb_sram_width_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_in_we;
    logic [4:0]  ram_in_addr_wr;
    logic [7:0]  ram_in_data_wr;

    logic [3:0]  a_rd_addr;
    logic [15:0] a_rd_data;
    logic        a_start;
    logic [4:0]  a_len;
    logic        a_ord;
    logic        a_busy;
    logic        a_done;
    logic [4:0]  a_words;

    logic [2:0]  b_rd_addr;
    logic [31:0] b_rd_data;
    logic        b_start;
    logic [3:0]  b_len;
    logic        b_ord;
    logic        b_busy;
    logic        b_done;
    logic [3:0]  b_words;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sram_width_packer #(.IN_W(8), .RATIO(2), .IN_DEPTH(32)) dut_a (
        .clk             (clk),
        .rst             (rst),
        .ram_in_we       (ram_in_we),
        .ram_in_addr_wr  (ram_in_addr_wr),
        .ram_in_data_wr  (ram_in_data_wr),
        .ram_out_addr_rd (a_rd_addr),
        .ram_out_data_rd (a_rd_data),
        .start_in        (a_start),
        .len_in          (a_len),
        .order_in        (a_ord),
        .busy_out        (a_busy),
        .done_out        (a_done),
        .words_done_out  (a_words)
    );

    sram_width_packer #(.IN_W(8), .RATIO(4), .IN_DEPTH(32)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .ram_in_we       (ram_in_we),
        .ram_in_addr_wr  (ram_in_addr_wr),
        .ram_in_data_wr  (ram_in_data_wr),
        .ram_out_addr_rd (b_rd_addr),
        .ram_out_data_rd (b_rd_data),
        .start_in        (b_start),
        .len_in          (b_len),
        .order_in        (b_ord),
        .busy_out        (b_busy),
        .done_out        (b_done),
        .words_done_out  (b_words)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic read_a(input int addr, input logic [15:0] exp, input string tag);
        a_rd_addr = 4'(addr);
        #1;
        check(tag, 64'(a_rd_data), 64'(exp));
    endtask

    task automatic read_b(input int addr, input logic [31:0] exp, input string tag);
        b_rd_addr = 3'(addr);
        #1;
        check(tag, 64'(b_rd_data), 64'(exp));
    endtask

    // Starts a transfer on instance A; the start edge is E0 and the cycle count
    // is the number of edges after E0 until busy_out is seen low.
    task automatic run_a(input int len, input bit ord, input int exp_cycles,
                         input int exp_words, input bit pulse, input string tag);
        int n;
        @(negedge clk);
        a_start = 1'b1;
        a_len   = 5'(len);
        a_ord   = ord;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        if (exp_cycles == 0) begin
            check({tag, "_busy0"}, 64'(a_busy), 64'd0);
        end else begin
            check({tag, "_busy1"}, 64'(a_busy), 64'd1);
            n = 0;
            while (a_busy && n < 500) begin
                @(posedge clk);
                #1;
                n++;
                if (pulse && n == 4) begin
                    a_start = 1'b1;
                    a_len   = 5'd1;
                    a_ord   = 1'b1;
                end
                if (pulse && n == 7)
                    a_start = 1'b0;
            end
            a_start = 1'b0;
            check({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
        end
        check({tag, "_done"}, 64'(a_done), 64'd1);
        check({tag, "_words"}, 64'(a_words), 64'(exp_words));
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        ram_in_we      = 1'b0;
        ram_in_addr_wr = '0;
        ram_in_data_wr = '0;
        a_rd_addr = '0; a_start = 1'b0; a_len = '0; a_ord = 1'b0;
        b_rd_addr = '0; b_start = 1'b0; b_len = '0; b_ord = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  64'(a_busy),  64'd0);
        check("rst_done",  64'(a_done),  64'd0);
        check("rst_words", 64'(a_words), 64'd0);
        check("rst_b_busy", 64'(b_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ram_in_we      = 1'b1;
            ram_in_addr_wr = 5'(i);
            ram_in_data_wr = 8'hA0 + 8'(i);
        end
        @(negedge clk);
        ram_in_we = 1'b0;

        // order 0, full length
        run_a(16, 1'b0, 48, 16, 1'b0, "o0_len16");
        read_a(0,  16'hA1A0, "o0_w0");
        read_a(3,  16'hA7A6, "o0_w3");
        read_a(15, 16'hBFBE, "o0_w15");

        // order 1, short transfer; word 3 keeps its earlier contents
        run_a(3, 1'b1, 9, 3, 1'b0, "o1_len3");
        read_a(0, 16'hA0A1, "o1_w0");
        read_a(1, 16'hA2A3, "o1_w1");
        read_a(2, 16'hA4A5, "o1_w2");
        read_a(3, 16'hA7A6, "o1_w3_kept");

        // zero length: done at the start edge, nothing written
        run_a(0, 1'b0, 0, 0, 1'b0, "len0");
        read_a(0, 16'hA0A1, "len0_w0_kept");

        // over-long request clamps to 16 words
        run_a(20, 1'b0, 48, 16, 1'b0, "len20");
        read_a(0,  16'hA1A0, "len20_w0");
        read_a(15, 16'hBFBE, "len20_w15");

        // reset 10 cycles into an order-1 transfer
        @(negedge clk);
        a_start = 1'b1; a_len = 5'd16; a_ord = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_words", 64'(a_words), 64'd3);
        check("mid_busy",  64'(a_busy),  64'd1);
        rst = 1'b1;
        #1;
        check("rstmid_busy",  64'(a_busy),  64'd0);
        check("rstmid_done",  64'(a_done),  64'd0);
        check("rstmid_words", 64'(a_words), 64'd0);
        read_a(0, 16'hA0A1, "rstmid_w0_kept");
        @(negedge clk);
        rst = 1'b0;

        // restart with start pulses while busy, which must be ignored
        run_a(16, 1'b0, 48, 16, 1'b1, "restart");
        read_a(0,  16'hA1A0, "restart_w0");
        read_a(2,  16'hA5A4, "restart_w2");
        read_a(15, 16'hBFBE, "restart_w15");

        // RATIO=4 instance, order 0, full length
        @(negedge clk);
        b_start = 1'b1; b_len = 4'd8; b_ord = 1'b0;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        check("r4_busy1", 64'(b_busy), 64'd1);
        n = 0;
        while (b_busy && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("r4_cycles", 64'(n), 64'd40);
        check("r4_done",   64'(b_done),  64'd1);
        check("r4_words",  64'(b_words), 64'd8);
        read_b(0, 32'hA3A2A1A0, "r4_w0");
        read_b(7, 32'hBFBEBDBC, "r4_w7");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
